// File: rtl/cpu_imm_pkg.sv
// cpu_imm_pkg: shared immediate-type encoding and field widths for the immediate extender
package cpu_imm_pkg;
    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_SX12 = 2'b11
    } imm_type_e;
    localparam int IMM8_W  = 8;
    localparam int ROT_W   = 4;
    localparam int IMM12_W = 12;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extension (instr, imm_type -> data)
//   instr    : instruction immediate field
//   imm_type : extension mode
//   data     : extended operand
module imm_extend_core
    import cpu_imm_pkg::*;
#(
    parameter int INSTR_W  = 24,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_type_e          imm_type,
    output logic [DATA_W-1:0]  data
);
    logic [DATA_W-1:0] imm8_z;
    logic [DATA_W-1:0] dp;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] br;
    logic [DATA_W-1:0] sx12;
    always_comb begin
        imm8_z = DATA_W'(instr[IMM8_W-1:0]);
        // rotate right: shift a doubled copy so wrapped bits fall into the low half
        dp     = DATA_W'({imm8_z, imm8_z} >> {instr[IMM8_W +: ROT_W], 1'b0});
        mem    = DATA_W'(instr[IMM12_W-1:0]);
        br     = DATA_W'($signed(instr)) << BR_SHIFT;
        sx12   = DATA_W'($signed(instr[IMM12_W-1:0]));
        data   = imm_type == IMM_DP  ? dp  :
                 imm_type == IMM_MEM ? mem :
                 imm_type == IMM_BR  ? br  : sx12;
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender for the decode stage
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : input handshake for instr/imm_type
//   out_valid, out_ready: output handshake for out_data
module imm_extend_pipe
    import cpu_imm_pkg::*;
#(
    parameter int INSTR_W  = 24,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  imm_type_e          imm_type,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);
    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    imm_type_e          s1_type;
    logic               s2_valid;
    logic [DATA_W-1:0]  s2_data;
    logic [DATA_W-1:0]  ext_data;
    logic               s1_adv;
    logic               s2_adv;

    imm_extend_core #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_core (
        .instr   (s1_instr),
        .imm_type(s1_type),
        .data    (ext_data)
    );

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_type  <= IMM_DP;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= ext_data;
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_instr <= instr;
                    s1_type  <= imm_type;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench with randomized traffic and a behavioural extension model
module tb_imm_extend_pipe;
    import cpu_imm_pkg::*;
    localparam int IW = 24;
    localparam int DW = 32;
    localparam int BS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] instr = '0;
    imm_type_e     imm_type = IMM_DP;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;

    int            checks = 0;
    int            errors = 0;
    int            n_out = 0;
    logic [DW-1:0] q[$];
    bit            ready_mode = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.INSTR_W(IW), .DATA_W(DW), .BR_SHIFT(BS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .imm_type (imm_type),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    function automatic logic [DW-1:0] model(input logic [IW-1:0] i, input logic [1:0] t);
        longint v;
        int     r;
        case (t)
            2'd0: begin
                v = longint'(i % 256);
                r = 2 * int'((i / 256) % 16);
                repeat (r) v = (v >> 1) | ((v % 2) << (DW - 1));
                return DW'(v);
            end
            2'd1: return DW'(i % 4096);
            2'd2: begin
                v = longint'(i);
                if (v >= (longint'(1) << (IW - 1))) v = v - (longint'(1) << IW);
                return DW'(v * (longint'(1) << BS));
            end
            default: begin
                v = longint'(i % 4096);
                if (v >= 2048) v = v - 4096;
                return DW'(v);
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [IW-1:0] i, input logic [1:0] t, input logic [DW-1:0] exp);
        instr    = i;
        imm_type = imm_type_e'(t);
        in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        if (!in_ready) check("send_timeout", DW'(in_ready), DW'(1));
        else q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", DW'(out_valid), DW'(1));
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got %h with nothing expected at %0t", out_data, $time);
                end else begin
                    check("out_data", out_data, q.pop_front());
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [IW-1:0] v;
        logic [1:0] t;
        idle(2);
        @(negedge clk);
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", DW'(in_ready), DW'(1));
        idle(1);

        send(24'h0fffff, 2'd2, 32'h003ffffc);
        send(24'hfffff0, 2'd2, 32'hffffffc0);
        send(24'h0000ab, 2'd0, 32'h000000ab);
        send(24'h0004ff, 2'd0, 32'hff000000);
        send(24'h000f01, 2'd0, 32'h00000004);
        send(24'hfffabc, 2'd1, 32'h00000abc);
        send(24'h000800, 2'd3, 32'hfffff800);
        send(24'h0007ff, 2'd3, 32'h000007ff);
        idle(4);
        check("directed_drained", DW'(q.size()), DW'(0));

        n0 = n_out;
        for (int k = 1; k <= 8; k++) begin
            t = 2'($urandom_range(0, 3));
            send(IW'(k), t, model(IW'(k), t));
        end
        repeat (2) @(negedge clk);
        #1;
        check("stream_count", DW'(n_out - n0), DW'(8));
        check("stream_drained", DW'(q.size()), DW'(0));
        idle(1);

        out_ready = 1'b0;
        send(24'h123456, 2'd2, model(24'h123456, 2'd2));
        send(24'h000c3f, 2'd0, model(24'h000c3f, 2'd0));
        fork
            send(24'h000fff, 2'd3, model(24'h000fff, 2'd3));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_in_ready", DW'(in_ready), DW'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(24'h800000, 2'd2, model(24'h800000, 2'd2));
        idle(4);
        check("bp_drained", DW'(q.size()), DW'(0));

        out_ready = 1'b0;
        send(24'h000111, 2'd1, model(24'h000111, 2'd1));
        send(24'h000222, 2'd1, model(24'h000222, 2'd1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        check("midrst_out_valid", DW'(out_valid), DW'(0));
        check("midrst_out_data", out_data, DW'(0));
        check("midrst_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);

        ready_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else begin
                case ($urandom_range(0, 5))
                    0: v = '0;
                    1: v = '1;
                    2: v = IW'(24'h800000);
                    3: v = IW'(24'h0007ff);
                    default: v = IW'($urandom);
                endcase
                t = 2'($urandom_range(0, 3));
                send(v, t, model(v, t));
            end
        end
        ready_mode = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        #1;
        check("final_drained", DW'(q.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
